mem_wb_stage: RTL and testbench

- Downstream neighbour of the Memory stage. It captures that stage's results (memory read data, ALU result, destination register RT, write-back controls) into a small skid FIFO.
- Selects the write-back value and drives the 128x128-bit register file write port with a valid/ready handshake.
- Exposes the oldest pending write for forwarding and counts retired instructions.

---
 rtl/mem_wb_stage.sv | 118 +++++++++++
 tb/tb_mem_wb_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Purpose : Memory->Write-back stage. Buffers completed instructions in a skid FIFO and
//           drives the register-file write port. Also exposes the oldest pending write
//           for forwarding and counts retired instructions.
// Latency : an entry pushed into an empty FIFO appears on wb_valid one cycle later.
//           Sustains one instruction per cycle while wb_ready is held high.
// Backpr. : in_ready depends only on occupancy (no wb_ready->in_ready path), so a full
//           FIFO refuses a push even in the cycle it pops.
//
// Ports:
//   clk, reset                  rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready           Memory stage handshake
//   mem_read_data, alu_result   write-back candidates; mem_to_reg picks one at push time
//   register_rt, reg_write      destination index and write enable
//   flush                       drops every queued entry and any push in the same cycle
//   wb_valid/wb_ready           register-file write handshake; wb_addr/wb_data are the payload
//   fwd_valid/fwd_reg/fwd_data  oldest pending write, for forwarding
//   retired_count               pops since reset; wraps modulo 2^CNT_W
module mem_wb_stage #(
   parameter int DATA_W = 128,
   parameter int REG_W  = 7,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [REG_W-1:0]  register_rt,
   input  logic              mem_to_reg,
   input  logic              reg_write,
   input  logic              flush,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [REG_W-1:0]  wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_reg,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retired_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [REG_W-1:0]  ent_addr [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [DEPTH-1:0]  ent_we;

   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [OCC_W-1:0]  occ;

   logic              empty;
   logic              head_we;
   logic              push;
   logic              pop;

   assign empty   = (occ == '0);
   assign head_we = ent_we[rd_ptr];

   // Outputs are gated by reset so they fall the moment reset asserts,
   // without waiting for the flops to clear.
   assign in_ready  = !reset && (occ < OCC_FULL);
   assign wb_valid  = !reset && !empty && head_we;
   assign wb_addr   = reset ? '0 : ent_addr[rd_ptr];
   assign wb_data   = reset ? '0 : ent_data[rd_ptr];
   assign fwd_valid = wb_valid;
   assign fwd_reg   = wb_addr;
   assign fwd_data  = wb_data;

   assign push = in_valid && in_ready && !flush;
   // A non-writing head needs no register-file slot and leaves immediately.
   assign pop  = !reset && !empty && (head_we ? wb_ready : 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         occ           <= '0;
         retired_count <= '0;
         ent_we        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] <= '0;
            ent_data[i] <= '0;
         end
      end else begin
         // A write accepted in a flush cycle still completes, so it is counted.
         if (pop) begin
            retired_count <= retired_count + CNT_W'(1);
         end

         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
         end else begin
            if (push) begin
               ent_addr[wr_ptr] <= register_rt;
               ent_data[wr_ptr] <= mem_to_reg ? mem_read_data : alu_result;
               ent_we[wr_ptr]   <= reg_write;
               wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   occ <= occ + OCC_W'(1);
               2'b01:   occ <= occ - OCC_W'(1);
               default: occ <= occ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   localparam int DATA_W = 128;
   localparam int REG_W  = 7;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] mem_read_data;
   logic [DATA_W-1:0] alu_result;
   logic [REG_W-1:0]  register_rt;
   logic              mem_to_reg;
   logic              reg_write;
   logic              flush;
   logic              wb_valid;
   logic              wb_ready;
   logic [REG_W-1:0]  wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              fwd_valid;
   logic [REG_W-1:0]  fwd_reg;
   logic [DATA_W-1:0] fwd_data;
   logic [CNT_W-1:0]  retired_count;

   int errors = 0;
   int checks = 0;

   localparam logic [DATA_W-1:0] ONES11 = {16{8'h11}};

   mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .mem_read_data (mem_read_data),
      .alu_result    (alu_result),
      .register_rt   (register_rt),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .flush         (flush),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .fwd_valid     (fwd_valid),
      .fwd_reg       (fwd_reg),
      .fwd_data      (fwd_data),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [REG_W-1:0] rt, input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] mrd, input logic m2r, input logic rw);
      in_valid      = v;
      register_rt   = rt;
      alu_result    = alu;
      mem_read_data = mrd;
      mem_to_reg    = m2r;
      reg_write     = rw;
   endtask

   // Inputs change and outputs are sampled at the falling edge, away from the active edge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      wb_ready = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);

      // Reset state
      cyc();
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wb_addr", wb_addr, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_fwd_valid", fwd_valid, 0);
      chk("rst_retired", retired_count, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Single ALU write, wb_ready high
      wb_ready = 1'b1;
      drive(1'b1, 7'd5, ONES11, '0, 1'b0, 1'b1);
      cyc();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t1_wb_valid", wb_valid, 1);
      chk("t1_wb_addr", wb_addr, 5);
      chk("t1_wb_data", wb_data, ONES11);
      chk("t1_fwd_valid", fwd_valid, 1);
      cyc();
      chk("t1_empty", wb_valid, 0);
      chk("t1_retired", retired_count, 1);

      // Load select
      wb_ready = 1'b0;
      drive(1'b1, 7'd127, 128'h40, 128'hDEADBEEF, 1'b1, 1'b1);
      cyc();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t2_wb_data", wb_data, 128'hDEADBEEF);
      chk("t2_wb_addr", wb_addr, 127);
      chk("t2_fwd_valid", fwd_valid, 1);
      chk("t2_fwd_reg", fwd_reg, 127);
      chk("t2_fwd_data", fwd_data, 128'hDEADBEEF);
      wb_ready = 1'b1;
      cyc();
      chk("t2_retired", retired_count, 2);
      chk("t2_empty", wb_valid, 0);

      // Backpressure: fill two entries, hold a third
      wb_ready = 1'b0;
      drive(1'b1, 7'd1, 128'hA1, '0, 1'b0, 1'b1);
      cyc();
      chk("t3_in_ready_occ1", in_ready, 1);
      drive(1'b1, 7'd2, 128'hB2, '0, 1'b0, 1'b1);
      cyc();
      chk("t3_in_ready_full", in_ready, 0);
      drive(1'b1, 7'd3, 128'hC3, '0, 1'b0, 1'b1);
      cyc();
      chk("t3_in_ready_held", in_ready, 0);
      chk("t3_head_stable", wb_addr, 1);
      chk("t3_wb_valid_held", wb_valid, 1);
      wb_ready = 1'b1;
      cyc();
      chk("t3_second_addr", wb_addr, 2);
      chk("t3_second_data", wb_data, 128'hB2);
      chk("t3_in_ready_back", in_ready, 1);
      chk("t3_retired_a", retired_count, 3);
      cyc();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t3_third_addr", wb_addr, 3);
      chk("t3_third_data", wb_data, 128'hC3);
      chk("t3_retired_b", retired_count, 4);
      cyc();
      chk("t3_empty", wb_valid, 0);
      chk("t3_retired_c", retired_count, 5);

      // Non-writing instruction pops without wb_ready
      wb_ready = 1'b0;
      drive(1'b1, 7'd9, 128'h99, '0, 1'b0, 1'b0);
      cyc();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t4_wb_valid", wb_valid, 0);
      chk("t4_fwd_valid", fwd_valid, 0);
      cyc();
      chk("t4_retired", retired_count, 6);
      chk("t4_in_ready", in_ready, 1);

      // Flush with two entries queued, wb_ready low, in_valid high
      drive(1'b1, 7'd10, 128'h10, '0, 1'b0, 1'b1);
      cyc();
      drive(1'b1, 7'd11, 128'h11, '0, 1'b0, 1'b1);
      cyc();
      chk("t5_full", in_ready, 0);
      drive(1'b1, 7'd12, 128'h12, '0, 1'b0, 1'b1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t5_wb_valid", wb_valid, 0);
      chk("t5_retired", retired_count, 6);
      chk("t5_in_ready", in_ready, 1);
      wb_ready = 1'b1;
      cyc();
      chk("t5_nothing_written", wb_valid, 0);
      chk("t5_retired_hold", retired_count, 6);

      // Flush with an accepted head write and a same-cycle push
      wb_ready = 1'b0;
      drive(1'b1, 7'd13, 128'h13, '0, 1'b0, 1'b1);
      cyc();
      drive(1'b1, 7'd14, 128'h14, '0, 1'b0, 1'b1);
      flush    = 1'b1;
      wb_ready = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t5b_push_dropped", wb_valid, 0);
      chk("t5b_fwd_valid", fwd_valid, 0);
      chk("t5b_retired", retired_count, 7);

      // Counter wrap: 17 retirements at one per cycle from zero
      reset = 1'b1;
      #1;
      chk("t6_rst_retired", retired_count, 0);
      cyc();
      reset = 1'b0;
      wb_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, REG_W'(i), DATA_W'(i), '0, 1'b0, 1'b1);
         cyc();
         chk("t6_stream_addr", wb_addr, DATA_W'(i));
         chk("t6_stream_vld", wb_valid, 1);
      end
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t6_retired_16", retired_count, 0);
      cyc();
      chk("t6_retired_wrap", retired_count, 1);
      chk("t6_empty", wb_valid, 0);

      // Reset asserted mid-stream
      wb_ready = 1'b0;
      drive(1'b1, 7'd20, 128'h20, '0, 1'b0, 1'b1);
      cyc();
      drive(1'b1, 7'd21, 128'h21, '0, 1'b0, 1'b1);
      cyc();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("t7_pending", wb_valid, 1);
      reset = 1'b1;
      #1;
      chk("t7_wb_valid", wb_valid, 0);
      chk("t7_in_ready", in_ready, 0);
      chk("t7_wb_addr", wb_addr, 0);
      chk("t7_wb_data", wb_data, 0);
      chk("t7_fwd_valid", fwd_valid, 0);
      chk("t7_retired", retired_count, 0);
      cyc();
      reset    = 1'b0;
      wb_ready = 1'b1;
      cyc();
      chk("t7_discarded", wb_valid, 0);
      chk("t7_retired_after", retired_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
